// File: rtl/decode_stage.sv
// Registered R-I CPU decode stage: valid/ready input, one-entry output register,
// load-use bubble insertion, saturating stall/illegal counters. Branch ops via DECODE_BRANCH_EN.
module decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_rt_s,
  output logic              imm_s,
  output logic              write_reg,
  output logic              alu_mem_s,
  output logic              rt_imm_s,
  output logic              mem_write,
  output logic [2:0]        alu_op,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] imm_ext,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
`ifdef DECODE_BRANCH_EN
  ,
  output logic              branch,
  output logic              br_ne
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef DECODE_BRANCH_EN
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  logic [5:0]  w_op, w_func;
  logic [4:0]  w_rs, w_rt, w_rd, w_wr_addr;
  logic [15:0] w_imm;
  logic        w_rd_rt_s, w_imm_s, w_write_reg, w_alu_mem_s, w_rt_imm_s, w_mem_write;
  logic [2:0]  w_alu_op;
  logic        w_illegal, w_uses_rt, w_hazard, w_accept;
  logic [DATA_W-1:0] w_imm_ext;
`ifdef DECODE_BRANCH_EN
  logic        w_branch, w_br_ne;
`endif

  logic              r_out_valid, r_rd_rt_s, r_imm_s, r_write_reg, r_alu_mem_s;
  logic              r_rt_imm_s, r_mem_write, r_illegal;
  logic [2:0]        r_alu_op;
  logic [4:0]        r_rs, r_rt, r_wr;
  logic [DATA_W-1:0] r_imm;
  logic [CNT_W-1:0]  r_stall_cnt, r_illegal_cnt;

  assign w_op   = in_instr[31:26];
  assign w_rs   = in_instr[25:21];
  assign w_rt   = in_instr[20:16];
  assign w_rd   = in_instr[15:11];
  assign w_func = in_instr[5:0];
  assign w_imm  = in_instr[15:0];

  // Decode table; illegal encodings leave every control at 0
  always_comb begin
    w_rd_rt_s   = 1'b0;
    w_imm_s     = 1'b0;
    w_write_reg = 1'b0;
    w_alu_mem_s = 1'b0;
    w_rt_imm_s  = 1'b0;
    w_mem_write = 1'b0;
    w_alu_op    = 3'b000;
    w_illegal   = 1'b0;
    w_uses_rt   = 1'b0;
`ifdef DECODE_BRANCH_EN
    w_branch    = 1'b0;
    w_br_ne     = 1'b0;
`endif
    case (w_op)
      OP_RTYPE: begin
        w_uses_rt   = 1'b1;
        w_write_reg = 1'b1;
        case (w_func)
          6'b100000: w_alu_op = 3'b100;
          6'b100010: w_alu_op = 3'b101;
          6'b100100: w_alu_op = 3'b000;
          6'b100101: w_alu_op = 3'b001;
          6'b100110: w_alu_op = 3'b010;
          6'b100111: w_alu_op = 3'b011;
          6'b101011: w_alu_op = 3'b110;
          6'b000100: w_alu_op = 3'b111;
          default: begin
            w_illegal   = 1'b1;
            w_write_reg = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_LW, OP_ANDI, OP_XORI, OP_SLTIU: begin
        w_rd_rt_s   = 1'b1;
        w_rt_imm_s  = 1'b1;
        w_write_reg = 1'b1;
        w_imm_s     = (w_op == OP_ADDI) || (w_op == OP_LW);
        w_alu_mem_s = (w_op == OP_LW);
        case (w_op)
          OP_ANDI:  w_alu_op = 3'b000;
          OP_XORI:  w_alu_op = 3'b010;
          OP_SLTIU: w_alu_op = 3'b110;
          default:  w_alu_op = 3'b100;
        endcase
      end
      OP_SW: begin
        w_uses_rt   = 1'b1;
        w_imm_s     = 1'b1;
        w_rt_imm_s  = 1'b1;
        w_mem_write = 1'b1;
        w_alu_op    = 3'b100;
      end
`ifdef DECODE_BRANCH_EN
      OP_BEQ, OP_BNE: begin
        w_uses_rt = 1'b1;
        w_imm_s   = 1'b1;
        w_alu_op  = 3'b101;
        w_branch  = 1'b1;
        w_br_ne   = (w_op == OP_BNE);
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_wr_addr = w_rd_rt_s ? w_rt : w_rd;
  assign w_imm_ext = w_imm_s ? DATA_W'($signed(w_imm)) : DATA_W'(w_imm);

  // Load-use: a held load feeding the incoming instruction forces one bubble
  assign w_hazard = r_out_valid && r_alu_mem_s && (r_wr != 5'd0) &&
                    ((w_rs == r_wr) || (w_uses_rt && (w_rt == r_wr)));
  assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_rd_rt_s     <= 1'b0;
      r_imm_s       <= 1'b0;
      r_write_reg   <= 1'b0;
      r_alu_mem_s   <= 1'b0;
      r_rt_imm_s    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_alu_op      <= 3'b000;
      r_rs          <= 5'd0;
      r_rt          <= 5'd0;
      r_wr          <= 5'd0;
      r_imm         <= '0;
      r_illegal     <= 1'b0;
      r_stall_cnt   <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (flush)         r_out_valid <= 1'b0;
      else if (w_accept) r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_rd_rt_s   <= w_rd_rt_s;
        r_imm_s     <= w_imm_s;
        r_write_reg <= w_write_reg;
        r_alu_mem_s <= w_alu_mem_s;
        r_rt_imm_s  <= w_rt_imm_s;
        r_mem_write <= w_mem_write;
        r_alu_op    <= w_alu_op;
        r_rs        <= w_rs;
        r_rt        <= w_rt;
        r_wr        <= w_wr_addr;
        r_imm       <= w_imm_ext;
        r_illegal   <= w_illegal;
      end
      if (w_hazard && out_ready && in_valid && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_accept && w_illegal && (r_illegal_cnt != '1))
        r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

`ifdef DECODE_BRANCH_EN
  logic r_branch, r_br_ne;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch <= 1'b0;
      r_br_ne  <= 1'b0;
    end else if (w_accept) begin
      r_branch <= w_branch;
      r_br_ne  <= w_br_ne;
    end
  end
  assign branch = r_branch;
  assign br_ne  = r_br_ne;
`endif

  assign out_valid   = r_out_valid;
  assign rd_rt_s     = r_rd_rt_s;
  assign imm_s       = r_imm_s;
  assign write_reg   = r_write_reg;
  assign alu_mem_s   = r_alu_mem_s;
  assign rt_imm_s    = r_rt_imm_s;
  assign mem_write   = r_mem_write;
  assign alu_op      = r_alu_op;
  assign rs_addr     = r_rs;
  assign rt_addr     = r_rt;
  assign wr_addr     = r_wr;
  assign imm_ext     = r_imm;
  assign illegal     = r_illegal;
  assign stall_cnt   = r_stall_cnt;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instruction-level model checked every cycle plus directed
// literal expectations; a CNT_W=2 twin exercises counter saturation.
module tb_decode_stage;

  typedef struct packed {
    logic        rd_rt_s, imm_s, write_reg, alu_mem_s, rt_imm_s, mem_write;
    logic [2:0]  alu_op;
    logic [4:0]  rs, rt, wr;
    logic [31:0] imm;
    logic        illegal, branch, br_ne;
  } bund_t;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = 32'h0;

  logic        in_ready, out_valid, rd_rt_s, imm_s, write_reg, alu_mem_s, rt_imm_s, mem_write, illegal;
  logic [2:0]  alu_op;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] imm_ext;
  logic [15:0] stall_cnt, illegal_cnt;

  logic        in_ready2, out_valid2, rd_rt_s2, imm_s2, write_reg2, alu_mem_s2, rt_imm_s2, mem_write2, illegal2;
  logic [2:0]  alu_op2;
  logic [4:0]  rs_addr2, rt_addr2, wr_addr2;
  logic [31:0] imm_ext2;
  logic [1:0]  stall_cnt2, illegal_cnt2;
`ifdef DECODE_BRANCH_EN
  logic        branch, br_ne, branch2, br_ne2;
`endif

  decode_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .rd_rt_s(rd_rt_s), .imm_s(imm_s), .write_reg(write_reg), .alu_mem_s(alu_mem_s),
    .rt_imm_s(rt_imm_s), .mem_write(mem_write), .alu_op(alu_op), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .wr_addr(wr_addr), .imm_ext(imm_ext), .illegal(illegal),
    .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
`ifdef DECODE_BRANCH_EN
    , .branch(branch), .br_ne(br_ne)
`endif
  );

  decode_stage #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .out_valid(out_valid2), .out_ready(out_ready),
    .rd_rt_s(rd_rt_s2), .imm_s(imm_s2), .write_reg(write_reg2), .alu_mem_s(alu_mem_s2),
    .rt_imm_s(rt_imm_s2), .mem_write(mem_write2), .alu_op(alu_op2), .rs_addr(rs_addr2),
    .rt_addr(rt_addr2), .wr_addr(wr_addr2), .imm_ext(imm_ext2), .illegal(illegal2),
    .stall_cnt(stall_cnt2), .illegal_cnt(illegal_cnt2)
`ifdef DECODE_BRANCH_EN
    , .branch(branch2), .br_ne(br_ne2)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction-set reference: what each encoding means, independent of pipeline timing
  function automatic bund_t dec(input logic [31:0] i);
    bund_t b;
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    b = '0;
    b.rs = i[25:21];
    b.rt = i[20:16];
    case (op)
      6'h00: begin
        b.write_reg = 1'b1;
        case (fn)
          6'h20: b.alu_op = 3'd4;
          6'h22: b.alu_op = 3'd5;
          6'h24: b.alu_op = 3'd0;
          6'h25: b.alu_op = 3'd1;
          6'h26: b.alu_op = 3'd2;
          6'h27: b.alu_op = 3'd3;
          6'h2B: b.alu_op = 3'd6;
          6'h04: b.alu_op = 3'd7;
          default: b.illegal = 1'b1;
        endcase
      end
      6'h08: begin b.imm_s = 1; b.rd_rt_s = 1; b.rt_imm_s = 1; b.write_reg = 1; b.alu_op = 3'd4; end
      6'h0C: begin b.rd_rt_s = 1; b.rt_imm_s = 1; b.write_reg = 1; b.alu_op = 3'd0; end
      6'h0E: begin b.rd_rt_s = 1; b.rt_imm_s = 1; b.write_reg = 1; b.alu_op = 3'd2; end
      6'h0B: begin b.rd_rt_s = 1; b.rt_imm_s = 1; b.write_reg = 1; b.alu_op = 3'd6; end
      6'h23: begin b.imm_s = 1; b.rd_rt_s = 1; b.rt_imm_s = 1; b.write_reg = 1; b.alu_op = 3'd4; b.alu_mem_s = 1; end
      6'h2B: begin b.imm_s = 1; b.rt_imm_s = 1; b.mem_write = 1; b.alu_op = 3'd4; end
`ifdef DECODE_BRANCH_EN
      6'h04, 6'h05: begin b.imm_s = 1; b.alu_op = 3'd5; b.branch = 1; b.br_ne = (op == 6'h05); end
`endif
      default: b.illegal = 1'b1;
    endcase
    if (b.illegal) begin
      b.rd_rt_s = 0; b.imm_s = 0; b.write_reg = 0; b.alu_mem_s = 0;
      b.rt_imm_s = 0; b.mem_write = 0; b.alu_op = 3'd0;
    end
    b.wr  = b.rd_rt_s ? i[20:16] : i[15:11];
    b.imm = b.imm_s ? {{16{i[15]}}, i[15:0]} : {16'h0, i[15:0]};
    return b;
  endfunction

  function automatic logic reads_rt(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
`ifdef DECODE_BRANCH_EN
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
`else
    return (op == 6'h00) || (op == 6'h2B);
`endif
  endfunction

  // Model state: what the stage holds and what it has counted
  logic  m_valid = 1'b0, m_acc = 1'b0, chk_en = 1'b0;
  bund_t m_b = '0;
  int    m_stall = 0, m_ill = 0;
  logic  hz, exp_ready;
  bund_t nb;

  always @(negedge clk) begin
    hz = m_valid && m_b.alu_mem_s && (m_b.wr != 5'd0) &&
         ((in_instr[25:21] == m_b.wr) || (reads_rt(in_instr) && in_instr[20:16] == m_b.wr));
    exp_ready = !flush && !hz && (!m_valid || out_ready);
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready",  64'(in_ready),  64'(exp_ready));
      chk("ctrl", 64'({rd_rt_s, imm_s, write_reg, alu_mem_s, rt_imm_s, mem_write, alu_op, illegal}),
                  64'({m_b.rd_rt_s, m_b.imm_s, m_b.write_reg, m_b.alu_mem_s, m_b.rt_imm_s,
                       m_b.mem_write, m_b.alu_op, m_b.illegal}));
      chk("addrs", 64'({rs_addr, rt_addr, wr_addr}), 64'({m_b.rs, m_b.rt, m_b.wr}));
      chk("imm_ext", 64'(imm_ext), 64'(m_b.imm));
      chk("stall_cnt", 64'(stall_cnt), 64'((m_stall > 65535) ? 65535 : m_stall));
      chk("illegal_cnt", 64'(illegal_cnt), 64'((m_ill > 65535) ? 65535 : m_ill));
      chk("sat_stall_cnt", 64'(stall_cnt2), 64'((m_stall > 3) ? 3 : m_stall));
      chk("sat_illegal_cnt", 64'(illegal_cnt2), 64'((m_ill > 3) ? 3 : m_ill));
      chk("twin_bundle", {out_valid2, in_ready2, rd_rt_s2, imm_s2, write_reg2, alu_mem_s2, rt_imm_s2,
                          mem_write2, alu_op2, illegal2, rs_addr2, rt_addr2, wr_addr2, imm_ext2},
                         {m_valid, exp_ready, m_b.rd_rt_s, m_b.imm_s, m_b.write_reg, m_b.alu_mem_s,
                          m_b.rt_imm_s, m_b.mem_write, m_b.alu_op, m_b.illegal, m_b.rs, m_b.rt,
                          m_b.wr, m_b.imm});
`ifdef DECODE_BRANCH_EN
      chk("branch", 64'({branch, br_ne, branch2, br_ne2}),
                    64'({m_b.branch, m_b.br_ne, m_b.branch, m_b.br_ne}));
`endif
    end
    m_acc = !rst && in_valid && exp_ready;
    if (rst) begin
      m_valid = 1'b0; m_b = '0; m_stall = 0; m_ill = 0;
    end else begin
      if (hz && out_ready && in_valid) m_stall++;
      if (m_acc) begin
        nb = dec(in_instr);
        if (nb.illegal) m_ill++;
        m_b = nb;
      end
      m_valid = flush ? 1'b0 : (m_acc ? 1'b1 : (out_ready ? 1'b0 : m_valid));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    int n;
    in_valid = 1'b1;
    in_instr = ins;
    n = 0;
    do begin step(); n++; end while (!m_acc && n < 20);
    n_chk++;
    if (!m_acc) begin
      n_err++;
      $display("FAIL accept_timeout: instr %h not accepted after %0d cycles", ins, n);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] alu_vec [7] = '{32'h00223822, 32'h00224825, 32'h00225026, 32'h00225827,
                               32'h0022602B, 32'h00226804, 32'h2024FFFF};

  initial begin
    step();
    chk_en = 1'b1;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_counters", 64'({stall_cnt, illegal_cnt}), 64'(0));
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(in_ready), 64'(1));

    send(32'h00221820);                       // add $3,$1,$2
    chk("add_alu_op", 64'(alu_op), 64'(3'b100));
    chk("add_wr", 64'(wr_addr), 64'(3));
    send(32'h30248000);                       // andi $4,$1,0x8000
    chk("andi_fields", 64'({alu_op, wr_addr}), 64'({3'b000, 5'd4}));
    chk("andi_imm", 64'(imm_ext), 64'(32'h00008000));

    foreach (alu_vec[k]) send(alu_vec[k]);
    send(32'h3824F0F0);                       // xori
    send(32'h2C24FFFF);                       // sltiu
    chk("sltiu_zext", 64'(imm_ext), 64'(32'h0000FFFF));

    send(32'h8C25FFFC);                       // lw $5,-4($1)
    chk("lw_imm", 64'(imm_ext), 64'(32'hFFFFFFFC));
    in_valid = 1'b1; in_instr = 32'h00A23020;  // add $6,$5,$2
    step();
    chk("bubble", 64'(out_valid), 64'(0));
    step();
    chk("after_bubble", 64'({out_valid, wr_addr}), 64'({1'b1, 5'd6}));
    in_valid = 1'b0;
    chk("stall_one", 64'(stall_cnt), 64'(1));
    send(32'h8C20FFFC);                       // lw $0
    send(32'h00023020);
    chk("lw_r0_no_stall", 64'(stall_cnt), 64'(1));

    send(32'h8C25FFFC);
    send(32'hAC650000);                       // sw $5,0($3): rt hazard
    send(32'h8C25FFFC);
    send(32'h20650004);                       // addi writes $5 only: no hazard
    chk("stall_sw", 64'(stall_cnt), 64'(2));

    send(32'h00223822);                       // sub $7
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00224024;  // and $8
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_ready", 64'(in_ready), 64'(0));
      chk("hold_wr", 64'({out_valid, wr_addr}), 64'({1'b1, 5'd7}));
    end
    out_ready = 1'b1;
    step();
    chk("release_wr", 64'(wr_addr), 64'(8));
    in_valid = 1'b0;
    step();
    chk("no_dup", 64'(out_valid), 64'(0));

    send(32'h8C25FFFC);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A23020;
    step(); step();
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    chk("stall_held", 64'(stall_cnt), 64'(3));

    send(32'hFC000000);
    send(32'h0000000F);
    chk("illegal_ctrl", 64'({illegal, write_reg, mem_write}), 64'(3'b100));
    chk("illegal_cnt2", 64'(illegal_cnt), 64'(2));
    send(32'h10221234);                       // beq
    send(32'hFC000001);
    send(32'hFC000002);
`ifdef DECODE_BRANCH_EN
    chk("illegal_cnt_end", 64'(illegal_cnt), 64'(4));
`else
    chk("illegal_cnt_end", 64'(illegal_cnt), 64'(5));
`endif
    chk("sat_twin", 64'(illegal_cnt2), 64'(3));

    send(32'h00224825);
    in_valid = 1'b1; in_instr = 32'h00225026; flush = 1'b1;
    step();
    chk("flush_valid", 64'(out_valid), 64'(0));
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_not_taken", 64'(out_valid), 64'(0));

`ifdef DECODE_BRANCH_EN
    send(32'h14220008);                       // bne $1,$2,8
    chk("bne", 64'({branch, br_ne, alu_op}), 64'({1'b1, 1'b1, 3'b101}));
`endif
    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
